// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC interpolator sequencer.
package cic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Strobes needed to push the last held sample (and the zeros behind it)
   // through every comb and integrator stage of the CIC.
   function automatic int unsigned drain_len(input int unsigned factor,
                                             input int unsigned stages);
      return (stages + 1) * factor;
   endfunction

   // Cycles from a CIC strobe to the matching m_valid pulse.
   localparam int unsigned OUT_LATENCY = 2;

endpackage

// File: rtl/cic_rate_div.sv
// Loadable clock divider producing the CIC output-rate strobe.
module cic_rate_div
   import cic_pkg::*;
#(
   parameter int unsigned DIV_W = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             load,
   input  logic [DIV_W-1:0] load_value,
   input  logic             enable,
   input  logic             clear,
   output logic             strobe
);

   logic [DIV_W-1:0] reload;
   logic [DIV_W-1:0] count;

   // Reload register, captured only when the sequencer starts a run.
   always_ff @(posedge i_clock) begin
      if (i_reset)
         reload <= '0;
      else if (load)
         reload <= load_value;
   end

   // Count 0..reload and wrap; held at zero while cleared.
   always_ff @(posedge i_clock) begin
      if (i_reset || clear)
         count <= '0;
      else if (enable)
         count <= (count == reload) ? '0 : count + 1'b1;
   end

   // Strobe in the cycle the count reaches the reload value.
   always_comb begin
      strobe = enable && (count == reload);
   end

endmodule

// File: rtl/cic_interp_sched.sv
// Sequencer for the CIC interpolator: input handshake, rate strobe,
// held comb sample, underflow zero-stuffing, drain and output capture.
module cic_interp_sched
   import cic_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned FACTOR  = 313,
   parameter int unsigned STAGES  = 5,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic [DIV_W-1:0] i_rate_div,
   input  logic [WIDTH-1:0] s_inph,
   input  logic [WIDTH-1:0] s_quad,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] o_cic_inph,
   output logic [WIDTH-1:0] o_cic_quad,
   output logic             o_cic_strobe,
   input  logic             i_cic_load,
   input  logic [WIDTH-1:0] i_cic_inph,
   input  logic [WIDTH-1:0] i_cic_quad,
   output logic [WIDTH-1:0] m_inph,
   output logic [WIDTH-1:0] m_quad,
   output logic             m_valid,
   output logic             o_busy,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_underflow
);

   localparam int unsigned DRAIN_N = drain_len(FACTOR, STAGES);
   localparam int unsigned DRAIN_W = $clog2(DRAIN_N + 1);

   state_t               state;
   state_t               next_state;
   logic                 strobe;
   logic                 div_load;
   logic                 div_run;
   logic [WIDTH-1:0]     held_inph;
   logic [WIDTH-1:0]     held_quad;
   logic [CNT_W-1:0]     underflow;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 drain_last;
   logic [OUT_LATENCY-2:0] strobe_pipe;

   cic_rate_div #(
      .DIV_W (DIV_W)
   ) u_rate_div (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .load       (div_load),
      .load_value (i_rate_div),
      .enable     (div_run),
      .clear      (!div_run),
      .strobe     (strobe)
   );

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; enable is only sampled outside DRAIN.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:  if (i_enable) next_state = PRIME;
         PRIME: begin
            if (s_valid)
               next_state = RUN;
            else if (!i_enable)
               next_state = IDLE;
         end
         RUN:   if (!i_enable) next_state = DRAIN;
         DRAIN: if (drain_last) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State-decoded outputs and divider control.
   always_comb begin
      s_ready  = 1'b0;
      div_load = 1'b0;
      div_run  = 1'b0;
      unique case (state)
         IDLE:    div_load = i_enable;
         PRIME:   s_ready  = s_valid;
         RUN: begin
            s_ready = i_cic_load;
            div_run = 1'b1;
         end
         DRAIN:   div_run  = 1'b1;
         default: ;
      endcase
      o_busy       = (state != IDLE);
      o_state      = state;
      o_cic_strobe = strobe;
      // The register is cleared one edge into DRAIN, so mask it for that first cycle.
      o_cic_inph   = (state == DRAIN) ? '0 : held_inph;
      o_cic_quad   = (state == DRAIN) ? '0 : held_quad;
      o_underflow  = underflow;
   end

   // Held comb sample: first sample in PRIME, then one per CIC load in RUN.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         held_inph <= '0;
         held_quad <= '0;
      end else begin
         unique case (state)
            PRIME: begin
               if (s_valid) begin
                  held_inph <= s_inph;
                  held_quad <= s_quad;
               end
            end
            RUN: begin
               if (i_cic_load) begin
                  held_inph <= s_valid ? s_inph : '0;
                  held_quad <= s_valid ? s_quad : '0;
               end
            end
            default: begin
               held_inph <= '0;
               held_quad <= '0;
            end
         endcase
      end
   end

   // Saturating count of loads that found no upstream sample.
   always_ff @(posedge i_clock) begin
      if (i_reset)
         underflow <= '0;
      else if (state == IDLE && i_enable)
         underflow <= '0;
      else if (state == RUN && i_cic_load && !s_valid && underflow != '1)
         underflow <= underflow + 1'b1;
   end

   // Strobes issued since entering DRAIN.
   always_ff @(posedge i_clock) begin
      if (i_reset || state != DRAIN)
         drain_cnt <= '0;
      else if (strobe)
         drain_cnt <= drain_cnt + 1'b1;
   end

   // Final drain strobe.
   always_comb begin
      drain_last = strobe && (drain_cnt == DRAIN_W'(DRAIN_N - 1));
   end

   // Delay the strobe to the cycle the CIC output is valid, then register it.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         strobe_pipe <= '0;
         m_valid     <= 1'b0;
         m_inph      <= '0;
         m_quad      <= '0;
      end else begin
         strobe_pipe[0] <= strobe;
         for (int unsigned i = 1; i < OUT_LATENCY - 1; i++)
            strobe_pipe[i] <= strobe_pipe[i-1];
         m_valid <= strobe_pipe[OUT_LATENCY-2];
         if (strobe_pipe[OUT_LATENCY-2]) begin
            m_inph <= i_cic_inph;
            m_quad <= i_cic_quad;
         end
      end
   end

endmodule

// File: tb/tb_cic_interp_sched.sv
// Directed/random bench for cic_interp_sched with a behavioural CIC stand-in.
module tb_cic_interp_sched;

   localparam int WIDTH  = 16;
   localparam int FACTOR = 4;
   localparam int STAGES = 2;
   localparam int DIV_W  = 16;
   localparam int CNT_W  = 8;
   localparam int DRAIN_STROBES = (STAGES + 1) * FACTOR;

   logic             clk = 1'b0;
   logic             i_reset, i_enable, s_valid, s_ready;
   logic [DIV_W-1:0] i_rate_div;
   logic [WIDTH-1:0] s_inph, s_quad, o_cic_inph, o_cic_quad;
   logic             o_cic_strobe, i_cic_load, m_valid, o_busy;
   logic [WIDTH-1:0] i_cic_inph, i_cic_quad, m_inph, m_quad;
   logic [1:0]       o_state;
   logic [CNT_W-1:0] o_underflow;

   cic_interp_sched #(
      .WIDTH  (WIDTH),
      .FACTOR (FACTOR),
      .STAGES (STAGES),
      .DIV_W  (DIV_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_rate_div   (i_rate_div),
      .s_inph       (s_inph),
      .s_quad       (s_quad),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .o_cic_inph   (o_cic_inph),
      .o_cic_quad   (o_cic_quad),
      .o_cic_strobe (o_cic_strobe),
      .i_cic_load   (i_cic_load),
      .i_cic_inph   (i_cic_inph),
      .i_cic_quad   (i_cic_quad),
      .m_inph       (m_inph),
      .m_quad       (m_quad),
      .m_valid      (m_valid),
      .o_busy       (o_busy),
      .o_state      (o_state),
      .o_underflow  (o_underflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: 0 idle, 1 prime, 2 run, 3 drain.
   typedef struct {
      int          due;
      logic [15:0] i;
      logic [15:0] q;
   } out_t;
   out_t pend[$];

   int          cyc = 0;
   int          m_state = 0, m_k = 0, m_reload = 0, m_dcnt = 0, m_phase = 0, m_under = 0;
   logic [15:0] m_hi = '0, m_hq = '0, acc_i = '0, acc_q = '0, last_i = '0, last_q = '0;
   logic        obs_strobe;
   logic [1:0]  obs_state;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive the CIC stand-in, compare all outputs, advance the model.
   task automatic step();
      logic        e_strobe, e_sready, e_mv;
      logic [15:0] e_ci, e_cq, e_mi, e_mq;
      e_strobe   = (m_state >= 2) && (m_k == m_reload);
      i_cic_load = e_strobe && (m_phase == 0);
      i_cic_inph = acc_i;
      i_cic_quad = acc_q;
      #1;
      e_ci     = (m_state == 2) ? m_hi : 16'h0;
      e_cq     = (m_state == 2) ? m_hq : 16'h0;
      e_sready = (m_state == 1) ? s_valid : (m_state == 2) ? i_cic_load : 1'b0;
      e_mv     = (pend.size() > 0) && (pend[0].due == cyc);
      e_mi     = e_mv ? pend[0].i : last_i;
      e_mq     = e_mv ? pend[0].q : last_q;
      chk("state",     32'(o_state),      32'(m_state));
      chk("busy",      32'(o_busy),       32'(m_state != 0));
      chk("strobe",    32'(o_cic_strobe), 32'(e_strobe));
      chk("s_ready",   32'(s_ready),      32'(e_sready));
      chk("cic_inph",  32'(o_cic_inph),   32'(e_ci));
      chk("cic_quad",  32'(o_cic_quad),   32'(e_cq));
      chk("underflow", 32'(o_underflow),  32'(m_under));
      chk("m_valid",   32'(m_valid),      32'(e_mv));
      chk("m_inph",    32'(m_inph),       32'(e_mi));
      chk("m_quad",    32'(m_quad),       32'(e_mq));
      obs_strobe = o_cic_strobe;
      obs_state  = o_state;
      if (i_reset) begin
         m_state = 0; m_k = 0; m_reload = 0; m_dcnt = 0; m_phase = 0; m_under = 0;
         m_hi = '0; m_hq = '0; acc_i = '0; acc_q = '0; last_i = '0; last_q = '0;
         pend.delete();
      end else begin
         if (e_mv) begin
            last_i = e_mi;
            last_q = e_mq;
            void'(pend.pop_front());
         end
         if (e_strobe) begin
            pend.push_back('{due: cyc + 2, i: acc_i + e_ci, q: acc_q + e_cq});
            acc_i   = acc_i + e_ci;
            acc_q   = acc_q + e_cq;
            m_phase = (m_phase + 1) % FACTOR;
         end
         case (m_state)
            0: begin
               m_k = 0; m_hi = '0; m_hq = '0;
               if (i_enable) begin
                  m_reload = int'(i_rate_div);
                  m_under  = 0;
                  m_state  = 1;
               end
            end
            1: begin
               m_k = 0;
               if (s_valid) begin
                  m_hi = s_inph; m_hq = s_quad; m_state = 2;
               end else if (!i_enable) begin
                  m_state = 0;
               end
            end
            2: begin
               m_k = (m_k == m_reload) ? 0 : m_k + 1;
               if (i_cic_load) begin
                  if (s_valid) begin
                     m_hi = s_inph; m_hq = s_quad;
                  end else begin
                     m_hi = '0; m_hq = '0;
                     if (m_under < (1 << CNT_W) - 1) m_under++;
                  end
               end
               if (!i_enable) begin
                  m_state = 3; m_dcnt = 0;
               end
            end
            default: begin
               m_hi = '0; m_hq = '0;
               m_k = (m_k == m_reload) ? 0 : m_k + 1;
               if (e_strobe) begin
                  m_dcnt++;
                  if (m_dcnt == DRAIN_STROBES) begin
                     m_state = 0; m_k = 0;
                  end
               end
            end
         endcase
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int  dcount;
      bit  done;
      i_reset = 1'b1; i_enable = 1'b0; i_rate_div = '0;
      s_valid = 1'b0; s_inph = '0; s_quad = '0;
      i_cic_load = 1'b0; i_cic_inph = '0; i_cic_quad = '0;
      @(posedge clk);
      @(negedge clk);
      // Reset state
      for (int n = 0; n < 3; n++) step();
      i_reset = 1'b0;
      step();

      // Start-up at div=3 with a constant sample
      i_enable = 1'b1; i_rate_div = 16'd3; s_valid = 1'b1;
      s_inph = 16'h0100; s_quad = 16'h0000;
      for (int n = 0; n < 80; n++) step();

      // One underflow, then random data
      done = 1'b0;
      for (int n = 0; n < 100; n++) begin
         s_inph = 16'($urandom); s_quad = 16'($urandom);
         if (!done && m_state == 2 && m_k == m_reload && m_phase == 0) begin
            s_valid = 1'b0; step(); s_valid = 1'b1; done = 1'b1;
         end else begin
            step();
         end
      end
      chk("underflow_once", 32'(o_underflow), 32'd1);

      // Stop and drain
      i_enable = 1'b0;
      dcount = 0;
      for (int n = 0; n < 200; n++) begin
         step();
         if (obs_state == 2'd3 && obs_strobe) dcount++;
      end
      chk("drain_strobes", 32'(dcount), 32'(DRAIN_STROBES));
      chk("idle_after_drain", 32'(o_busy), 32'd0);

      // div=0, random input with gaps; rate changes while busy are ignored
      i_enable = 1'b1; i_rate_div = 16'd0; s_valid = 1'b1;
      s_inph = 16'h0001; s_quad = 16'h0000;
      step();
      for (int n = 0; n < 80; n++) begin
         s_inph  = (n < 4) ? 16'h0 : 16'($urandom);
         s_quad  = 16'($urandom);
         s_valid = ($urandom_range(0, 3) != 0);
         if (n == 5) i_rate_div = 16'($urandom_range(1, 9));
         step();
      end

      // Reset in the middle of RUN, then restart
      i_reset = 1'b1;
      step();
      i_reset = 1'b0; i_enable = 1'b0;
      step();
      chk("state_after_reset", 32'(o_state), 32'd0);
      chk("underflow_after_reset", 32'(o_underflow), 32'd0);
      i_enable = 1'b1; i_rate_div = 16'd0; s_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
         s_inph = 16'($urandom); s_quad = 16'($urandom);
         step();
      end

      // Starve the input until the underflow count saturates
      s_valid = 1'b0;
      for (int n = 0; n < 1100; n++) step();
      chk("underflow_sat", 32'(o_underflow), 32'(8'hFF));

      i_enable = 1'b0;
      for (int n = 0; n < 40; n++) step();
      chk("final_idle", 32'(o_state), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cic_interp_sched.md
Name: cic_interp_sched

Overview:
Sequencer for the CIC interpolator datapath.
- Accepts I/Q input samples from an upstream valid/ready source.
- Generates the CIC output-rate strobe (CIC i_ready) from a programmable clock divider.
- Presents each input sample to the CIC combs until the CIC signals consumption.
- Captures CIC output into a registered, valid-flagged stream for the DAC path.
- Manages start, underflow zero-stuffing and a flush/drain on stop.

Parameters:
WIDTH, 16, I/Q sample width; must match the CIC instance.
FACTOR, 313, CIC interpolation factor; must match the CIC instance.
STAGES, 5, CIC stage count; used for drain length.
DIV_W, 16, width of the rate divider value.
CNT_W, 16, width of the underflow counter.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  run request (level)
i_rate_div  in  DIV_W  clocks per CIC strobe minus 1
s_inph  in  WIDTH  upstream I sample
s_quad  in  WIDTH  upstream Q sample
s_valid  in  1  upstream sample valid
s_ready  out  1  upstream sample accepted this cycle
o_cic_inph  out  WIDTH  held I sample to CIC comb input
o_cic_quad  out  WIDTH  held Q sample to CIC comb input
o_cic_strobe  out  1  CIC rate strobe (drives CIC i_ready)
i_cic_load  in  1  CIC consumed the held sample (CIC o_ready)
i_cic_inph  in  WIDTH  CIC output I
i_cic_quad  in  WIDTH  CIC output Q
m_inph  out  WIDTH  registered output I
m_quad  out  WIDTH  registered output Q
m_valid  out  1  output sample valid, single-cycle pulse, no backpressure
o_busy  out  1  state != IDLE
o_state  out  2  IDLE=0, PRIME=1, RUN=2, DRAIN=3
o_underflow  out  CNT_W  saturating underflow count

Behaviour:
- Clocking and reset: clock i_clock; reset i_reset, synchronous, active-high.
- Reset values: state IDLE; all data outputs 0; s_ready, o_cic_strobe and m_valid 0; o_underflow 0; divider counter 0.
- Reset mid-operation aborts immediately to IDLE. The CIC shares i_reset, so no drain is performed.
- IDLE:
  - no strobes; s_ready 0; held sample 0.
  - i_enable=1 latches i_rate_div into the divider reload register, clears the underflow count, and moves to PRIME.
- PRIME:
  - no strobes.
  - s_ready = s_valid (combinational).
  - On the first s_valid, loads the sample into the held register and moves to RUN.
  - If i_enable drops before a sample arrives, returns to IDLE.
- RUN:
  - Divider counts 0..div. o_cic_strobe is 1 in the cycle the count equals div, and the count then wraps to 0.
  - div=0 gives a strobe every cycle.
  - On i_cic_load=1, s_ready = i_cic_load (combinational).
    - If s_valid=1, the next sample is loaded into the held register at the following edge.
    - If s_valid=0, the held register loads 0 and o_underflow increments, saturating at all-ones.
  - At most one sample is accepted per i_cic_load pulse. s_ready is 0 in all other cycles.
  - i_enable=0 moves to DRAIN at the next edge.
- DRAIN:
  - s_ready 0; held sample forced to 0; strobes continue.
  - A strobe counter counts (STAGES+1)*FACTOR strobes, then moves to IDLE.
  - i_enable is ignored in DRAIN; re-enable takes effect only from IDLE.
- Output capture: a strobe in cycle t updates the CIC integrators at the t/t+1 edge.
  - The block registers i_cic_inph/quad at the end of cycle t+1.
  - m_valid=1 in cycle t+2, so latency from strobe to m_valid is 2 cycles.
  - m_valid pulses continue through DRAIN, including the last strobe's output after entering IDLE.
  - m_inph/quad hold their value between pulses.
- i_rate_div changes while busy are ignored.

Decomposition:
- Package cic_pkg holds:
  - state enum (IDLE/PRIME/RUN/DRAIN, 2 bits);
  - drain-length function (STAGES+1)*FACTOR;
  - strobe-to-output latency constant (2).
- One natural sub-module, cic_rate_div: loadable divider producing the strobe, with enable and synchronous clear.
- Top: FSM, held-sample register, underflow counter, drain counter, output capture.

Test Plan:
(Bench parameters FACTOR=4, STAGES=2, actual CIC instance wired in.)
1. Reset, then i_enable=1, i_rate_div=3, s_valid held 1 with sample 0x0100/0x0000.
   -> o_state 1 then 2.
   -> o_cic_strobe every 4 cycles.
   -> s_ready pulses once per i_cic_load, i.e. every 16 cycles.
   -> m_valid 2 cycles after each strobe.
2. In RUN, drop s_valid for one i_cic_load.
   -> o_cic_inph=0 for that period; o_underflow=1.
   -> Next valid sample accepted on the following load.
3. In RUN, i_enable=0.
   -> o_state=3; s_ready 0.
   -> Exactly 12 further strobes, then o_state=0 and o_busy=0.
   -> Last m_valid 2 cycles after the final strobe.
4. i_rate_div=0 with continuous input.
   -> Strobe every cycle; s_ready every 4 cycles.
   -> Impulse 0x0001 yields a CIC output matching the golden model.
5. Assert i_reset in the middle of RUN.
   -> Next cycle: o_state=0; all outputs 0; o_underflow=0.
   -> Re-enable restarts at PRIME.
6. Force 65535 underflows (CNT_W=16) -> o_underflow saturates at 0xFFFF and does not wrap.
